// File: rtl/pipe_adder.sv
// pipe_adder: pipelined adder/subtractor, one carry slice per stage, valid/ready handshake.
// Optional signed saturation on overflow is enabled with `define PIPE_ADDER_SAT_EN.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             SAT,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             OVF
);
  localparam int W = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end
  logic [STAGES-1:0] v_q, v_d, c_q, c_d, sat_q, sat_d, vp, cp, satp;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, ap, bp, sp;
  logic ovf_q, ovf_d, en, sat_in, unused;
`ifdef PIPE_ADDER_SAT_EN
  assign sat_in = SAT;
`else
  assign sat_in = 1'b0;
`endif
  // Stage k sees either the fresh operands (k=0) or stage k-1's registers.
  for (genvar g = 0; g < STAGES; g++) begin : g_prev
    if (g == 0) begin : g_head
      assign ap[g]   = A;
      assign bp[g]   = B ^ {WIDTH{SUB}};
      assign cp[g]   = SUB;
      assign sp[g]   = '0;
      assign vp[g]   = in_valid;
      assign satp[g] = sat_in;
    end else begin : g_body
      assign ap[g]   = a_q[g-1];
      assign bp[g]   = b_q[g-1];
      assign cp[g]   = c_q[g-1];
      assign sp[g]   = s_q[g-1];
      assign vp[g]   = v_q[g-1];
      assign satp[g] = sat_q[g-1];
    end
  end
  always_comb begin
    en = !v_q[L] || out_ready;
    a_d = ap;
    b_d = bp;
    s_d = sp;
    v_d = vp;
    sat_d = satp;
    c_d = '0;
    for (int k = 0; k < STAGES; k++)
      {c_d[k], s_d[k][k*W +: W]} = {1'b0, ap[k][k*W +: W]} + {1'b0, bp[k][k*W +: W]} + {{W{1'b0}}, cp[k]};
    // MSB carry-in is recovered as a^b^sum at the top bit.
    ovf_d = ap[L][WIDTH-1] ^ bp[L][WIDTH-1] ^ s_d[L][WIDTH-1] ^ c_d[L];
`ifdef PIPE_ADDER_SAT_EN
    if (sat_d[L] && ovf_d)
      s_d[L] = ap[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      sat_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q   <= v_d;
      c_q   <= c_d;
      sat_q <= sat_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  assign in_ready  = en;
  assign out_valid = v_q[L];
  assign O         = s_q[L];
  assign COUT      = c_q[L];
  assign OVF       = ovf_q;
  assign unused    = ^{a_q[L], b_q[L], sat_q[L]};
endmodule
